// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, downstream instruction
// valid/ready with decode field, and the redirect from execute.
interface fetch_unit_if #(
  parameter int CNT_W = 16
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             imem_ack;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [11:0]      opcode;
  logic [31:0]      pc;
  logic [31:0]      pc_plus8;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] fetch_count;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, pc, pc_plus8, fetch_count,
    input  imem_rdata, imem_ack, instr_ready, redirect, redirect_pc
  );

  // Memory / control-unit / execute side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, pc, pc_plus8, fetch_count,
    output imem_rdata, imem_ack, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads over req/ack and
// hands the fetched word to the control unit over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      instr_reg, instr_next;
  logic             instr_valid_reg, instr_valid_next;
  logic [CNT_W-1:0] fetch_count_reg, fetch_count_next;
  logic             redir_pend_reg, redir_pend_next;
  logic [31:0]      pend_pc_reg, pend_pc_next;

  logic [31:0] redir_tgt;
  logic        accept;

  // Targets are always word aligned; masking keeps every input bit consumed.
  assign redir_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
  assign accept    = instr_valid_reg & bus.instr_ready & ~bus.redirect;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        // Data is kept only when nothing has redirected this request.
        if (bus.imem_ack && !redir_pend_reg && !bus.redirect) begin
          state_next = VALID;
        end
      end
      VALID: begin
        if (bus.redirect || accept) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM outputs ----------------
  always_comb begin
    bus.imem_req = 1'b0;
    case (state_reg)
      REQ:     bus.imem_req = 1'b1;
      default: bus.imem_req = 1'b0;
    endcase
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_valid_next = instr_valid_reg;
    fetch_count_next = fetch_count_reg;
    redir_pend_next  = redir_pend_reg;
    pend_pc_next     = pend_pc_reg;
    case (state_reg)
      IDLE: begin
        if (bus.redirect) begin
          pc_next = redir_tgt;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            pc_next         = redir_tgt;
            redir_pend_next = 1'b0;
          end else if (redir_pend_reg) begin
            pc_next         = pend_pc_reg;
            redir_pend_next = 1'b0;
          end else begin
            instr_next       = bus.imem_rdata;
            instr_valid_next = 1'b1;
          end
        end else if (bus.redirect) begin
          // The address bus must not move mid-request; apply on completion.
          pend_pc_next    = redir_tgt;
          redir_pend_next = 1'b1;
        end
      end
      VALID: begin
        if (bus.redirect) begin
          pc_next          = redir_tgt;
          instr_valid_next = 1'b0;
        end else if (accept) begin
          pc_next          = pc_reg + 32'd4;
          fetch_count_next = fetch_count_reg + CNT_W'(1);
          instr_valid_next = 1'b0;
        end
      end
      default: begin
        instr_valid_next = 1'b0;
        redir_pend_next  = 1'b0;
      end
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'h0;
      instr_valid_reg <= 1'b0;
      fetch_count_reg <= '0;
      redir_pend_reg  <= 1'b0;
      pend_pc_reg     <= 32'h0;
    end else begin
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
      fetch_count_reg <= fetch_count_next;
      redir_pend_reg  <= redir_pend_next;
      pend_pc_reg     <= pend_pc_next;
    end
  end

  // ---------------- outputs ----------------
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.opcode      = instr_reg[31:20];
  assign bus.pc          = pc_reg;
  assign bus.pc_plus8    = pc_reg + 32'd8;
  assign bus.fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable ack delay,
// expected-instruction scoreboard checked by an independent monitor.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.CNT_W(16)) fif ();
  fetch_unit_if #(.CNT_W(16)) fif2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif.master)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif2.master)
  );

  // Second instance sees a zero-wait memory acking in the request cycle.
  assign fif2.imem_ack   = fif2.imem_req;
  assign fif2.imem_rdata = {~fif2.imem_addr[15:0], fif2.imem_addr[15:0]};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   mem_delay   = 0;
  int   wcnt        = 0;
  int   exp_cnt     = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'hE1A0_1002;
      32'h0000_0004: mem_word = 32'hE3A0_0005;
      32'h0000_0008: mem_word = 32'hDEAD_BEEF;
      32'h0000_0100: mem_word = 32'h1AFF_FFFE;
      default:       mem_word = {~a[15:0], a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [31:0] req_addr, input int budget);
    int n = 0;
    while (!fif.instr_valid && n < budget) begin
      if (fif.imem_req) chk("imem_addr_stable", fif.imem_addr, req_addr);
      tick();
      n++;
    end
    if (!fif.instr_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_valid: instr_valid=0, expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic accept_pulse();
    fif.instr_ready = 1'b1;
    tick();
    fif.instr_ready = 1'b0;
  endtask

  // Instruction memory for the main instance.
  always @(negedge clk) begin
    if (!rst_n || !fif.imem_req) begin
      fif.imem_ack = 1'b0;
      wcnt = 0;
    end else if (fif.imem_ack) begin
      fif.imem_ack = 1'b0;
      wcnt = 0;
    end else if (wcnt >= mem_delay) begin
      fif.imem_ack   = 1'b1;
      fif.imem_rdata = mem_word(fif.imem_addr);
    end else begin
      wcnt++;
    end
  end

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      exp_cnt = 0;
    end else if (fif.instr_valid && fif.instr_ready && !fif.redirect) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_instr: got pc %h instr %h, expected none", fif.pc, fif.instr);
      end else begin
        e = exp_q.pop_front();
        chk("instr", fif.instr, e.instr);
        chk("opcode", 32'(fif.opcode), 32'(e.instr[31:20]));
        chk("pc", fif.pc, e.pc);
        chk("pc_plus8", fif.pc_plus8, e.pc + 32'd8);
        chk("fetch_count_at_accept", 32'(fif.fetch_count), 32'(exp_cnt));
        exp_cnt++;
      end
    end
  end

  initial begin
    fif.instr_ready  = 1'b0;
    fif.redirect     = 1'b0;
    fif.redirect_pc  = 32'h0;
    fif.imem_ack     = 1'b0;
    fif.imem_rdata   = 32'h0;
    fif2.instr_ready = 1'b0;
    fif2.redirect    = 1'b0;
    fif2.redirect_pc = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", 32'(fif.imem_req), 32'd0);
    chk("rst_instr_valid", 32'(fif.instr_valid), 32'd0);
    chk("rst_pc", fif.pc, 32'h0);
    chk("rst_instr", fif.instr, 32'h0);
    chk("rst_fetch_count", 32'(fif.fetch_count), 32'd0);
    chk("rst_pc_dut2", fif2.pc, 32'hFFFF_FFFC);

    // Zero-wait first fetch
    mem_delay = 0;
    exp_q.push_back('{32'hE1A0_1002, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("c1_imem_req", 32'(fif.imem_req), 32'd1);
    chk("c1_imem_addr", fif.imem_addr, 32'h0);
    chk("c1_dut2_addr", fif2.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("c2_instr_valid", 32'(fif.instr_valid), 32'd1);
    chk("c2_opcode", 32'(fif.opcode), 32'hE1A);
    chk("c2_pc", fif.pc, 32'h0);
    chk("c2_pc_plus8", fif.pc_plus8, 32'h8);
    chk("dut2_valid", 32'(fif2.instr_valid), 32'd1);
    chk("dut2_instr", fif2.instr, 32'h0003_FFFC);
    chk("dut2_pc_plus8", fif2.pc_plus8, 32'h0000_0004);
    fif2.instr_ready = 1'b1;

    // Back-pressure: outputs hold, no new request
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        fif2.instr_ready = 1'b0;
        chk("dut2_wrap_addr", fif2.imem_addr, 32'h0);
        chk("dut2_count", 32'(fif2.fetch_count), 32'd1);
      end
      chk("stall_instr", fif.instr, 32'hE1A0_1002);
      chk("stall_pc", fif.pc, 32'h0);
      chk("stall_imem_req", 32'(fif.imem_req), 32'd0);
    end

    // Accept; next fetch through a 3-cycle memory
    mem_delay = 3;
    exp_q.push_back('{32'hE3A0_0005, 32'h4});
    accept_pulse();
    chk("acc1_count", 32'(fif.fetch_count), 32'd1);
    chk("acc1_addr", fif.imem_addr, 32'h4);
    wait_valid(32'h4, 20);
    accept_pulse();
    chk("acc2_addr", fif.imem_addr, 32'h8);
    chk("acc2_count", 32'(fif.fetch_count), 32'd2);

    // Two redirects while the request to 8 is outstanding; newest wins
    fif.redirect = 1'b1;
    fif.redirect_pc = 32'h0000_02F0;
    tick();
    fif.redirect_pc = 32'h0000_0103;
    tick();
    fif.redirect = 1'b0;
    exp_q.push_back('{32'h1AFF_FFFE, 32'h100});
    for (int n = 0; n < 20 && fif.imem_addr == 32'h8; n++) begin
      chk("pend_valid_low", 32'(fif.instr_valid), 32'd0);
      tick();
    end
    chk("redir_addr", fif.imem_addr, 32'h100);
    chk("redir_req", 32'(fif.imem_req), 32'd1);
    chk("redir_count", 32'(fif.fetch_count), 32'd2);
    wait_valid(32'h100, 20);
    mem_delay = 0;
    accept_pulse();
    chk("acc3_count", 32'(fif.fetch_count), 32'd3);

    // Redirect and ready together in VALID: dropped, not counted
    tick();
    chk("v104_valid", 32'(fif.instr_valid), 32'd1);
    chk("v104_pc", fif.pc, 32'h104);
    fif.instr_ready = 1'b1;
    fif.redirect = 1'b1;
    fif.redirect_pc = 32'h0000_0200;
    tick();
    fif.instr_ready = 1'b0;
    fif.redirect = 1'b0;
    chk("rv_addr", fif.imem_addr, 32'h200);
    chk("rv_req", 32'(fif.imem_req), 32'd1);
    chk("rv_valid", 32'(fif.instr_valid), 32'd0);
    chk("rv_count", 32'(fif.fetch_count), 32'd3);
    exp_q.push_back('{32'hFDFF_0200, 32'h200});
    wait_valid(32'h200, 20);
    mem_delay = 3;
    accept_pulse();
    chk("acc4_count", 32'(fif.fetch_count), 32'd4);

    // Asynchronous reset during a wait state
    tick();
    chk("wait_req", 32'(fif.imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_imem_req", 32'(fif.imem_req), 32'd0);
    chk("arst_pc", fif.pc, 32'h0);
    chk("arst_valid", 32'(fif.instr_valid), 32'd0);
    chk("arst_count", 32'(fif.fetch_count), 32'd0);
    chk("arst_pc_dut2", fif2.pc, 32'hFFFF_FFFC);
    exp_q.delete();
    mem_delay = 0;
    exp_q.push_back('{32'hE1A0_1002, 32'h0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wait_valid(32'h0, 20);
    accept_pulse();
    chk("post_rst_count", 32'(fif.fetch_count), 32'd1);
    chk("post_rst_addr", fif.imem_addr, 32'h4);

    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that directly feeds the control unit.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Captures the returned word and presents it downstream with a valid/ready handshake, plus the 12-bit decode field instr[31:20] (cond + op + funct) consumed by the control unit.
- Accepts a redirect (taken branch) from the execute side.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word address of request; low 2 bits always 0
- imem_rdata  in  32  read data, valid when imem_ack=1
- imem_ack  in  1  memory completion strobe, one cycle
- instr_valid  out  1  instr/opcode/pc outputs hold a fetched instruction
- instr_ready  in  1  downstream accepts the instruction this cycle
- instr  out  32  fetched instruction word
- opcode  out  12  instr[31:20], to control unit
- pc  out  32  address of instr
- pc_plus8  out  32  pc+8 (architectural PC read value)
- redirect  in  1  taken branch / flush pulse
- redirect_pc  in  32  new fetch address; bits[1:0] forced to 0
- fetch_count  out  CNT_W  number of accepted instructions, wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_count=0, redir_pend=0.
- Reset mid-transaction abandons the outstanding request. A late imem_ack arriving while in IDLE is ignored.
- States:
  - IDLE: imem_req=0. Next cycle unconditionally goes to REQ.
  - REQ: imem_req=1, imem_addr=pc, both stable until ack.
    - On imem_ack with redir_pend=0: instr<=imem_rdata, instr_valid<=1, go to VALID.
    - On imem_ack with redir_pend=1: discard data, pc<=pend_pc, redir_pend<=0, stay in REQ.
    - imem_ack may arrive in the same cycle imem_req first rises (zero-wait memory).
  - VALID: instr_valid=1, imem_req=0.
    - Accept = instr_valid & instr_ready & !redirect. On accept: pc<=pc+4, fetch_count++, instr_valid<=0, go to REQ.
    - Otherwise hold all outputs stable.
- Redirect:
  - In VALID: instruction is dropped (not counted), pc<={redirect_pc[31:2],2'b00}, instr_valid<=0, go to REQ. Redirect overrides a simultaneous instr_ready.
  - In REQ: imem_addr must not change mid-request, so latch pend_pc and set redir_pend=1. If a second redirect arrives before ack, the newest pend_pc wins.
  - In REQ when the same cycle also has imem_ack: data is discarded, pc<=new target, stay in REQ.
  - In IDLE: pc<=target, go to REQ.
- opcode = instr[31:20]; pc_plus8 = pc+8. Both combinational from registered values, modulo 2^32.
- Timing:
  - Zero-wait throughput is one instruction per 2 cycles.
  - Latency from REQ entry to instr_valid is (ack cycle + 1).
- pc increment wraps 32'hFFFF_FFFC -> 32'h0000_0000. fetch_count wraps at 2^CNT_W-1 -> 0.
- imem_ack outside REQ is ignored.

Test Plan:
- Reset release, zero-wait memory returning 32'hE1A0_1002 at addr 0 -> imem_req at cycle 1 with addr 0; instr_valid at cycle 2, opcode=12'hE1A, pc=0, pc_plus8=8.
- instr_ready=0 for 5 cycles -> instr/opcode/pc stable and no new imem_req. Then ready=1 -> fetch_count=1 and next request addr=4.
- Memory with 3-cycle ack delay, words 32'hE3A0_0005 and 32'h1AFF_FFFE -> imem_addr stable across wait cycles; opcodes 12'hE3A then 12'h1AF delivered in order.
- redirect with redirect_pc=32'h0000_0103 while a request to 8 is pending -> ack data at 8 discarded, next request addr=32'h100, no instr_valid for addr 8, fetch_count unchanged.
- redirect and instr_ready together in VALID -> instruction not counted, next imem_addr=redirect target.
- RESET_PC=32'hFFFF_FFFC, accept one instruction -> next imem_addr=0. Assert rst_n=0 during a wait state -> imem_req=0 immediately, pc=RESET_PC.
